mmio_bridge_demux: RTL and testbench
====================================

Name: mmio_bridge_demux

Overview:
- CPU-side load/store port routed to one of four memory-mapped devices.
- The address decoder demultiplexes one CPU transaction onto a one-hot device select.
- A request/acknowledge handshake runs with timeout and error reporting.
- Read data from the selected device is registered and returned to the CPU.
- Sits between the pipeline memory stage and the peripheral bus; it is the write/demux counterpart of the datapath select muxes.

Parameters:
- DATA_W, 32, CPU and device data width.
- TIMEOUT, 16, cycles in ACCESS without device ack before error response (range 2..255).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- cpu_req  input  1  transaction request, sampled only in IDLE
- cpu_we  input  1  1 = store, 0 = load
- cpu_addr  input  32  byte address
- cpu_wdata  input  DATA_W  store data
- cpu_ready  output  1  one-cycle completion pulse
- cpu_rdata  output  DATA_W  load data, valid while cpu_ready=1
- cpu_err  output  1  error flag, valid while cpu_ready=1
- dev_sel  output  4  one-hot device select, held through ACCESS
- dev_we  output  1  write strobe qualifier, valid with dev_sel
- dev_addr  output  4  word offset inside device (latched addr[3:0] with [1:0] zero)
- dev_wdata  output  DATA_W  latched store data
- dev_ack  input  4  per-device acknowledge; only bit of the selected device is honoured
- dev_rdata  input  4*DATA_W  device read buses concatenated, device i at [i*DATA_W +: DATA_W]

Behaviour:
- Address map:
  - Mapped only if addr[31:16]==0, addr[15:6]==10'h1FC and addr[1:0]==0 (range 0x7F00–0x7F3F).
  - Device index = addr[5:4].
  - Any other address is an error; misaligned addresses are errors too.
- Reset (async, rst_n=0): state=IDLE; cpu_ready=0, cpu_err=0, cpu_rdata=0, dev_sel=0, dev_we=0, dev_addr=0, dev_wdata=0; timeout counter=0.
  - Reset mid-transaction aborts it immediately.
  - No response is produced after reset release.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On cpu_req=1, latch cpu_we, cpu_addr and cpu_wdata, then decode.
  - Mapped: next state ACCESS; dev_sel, dev_we, dev_addr and dev_wdata are registered and valid from the first ACCESS cycle.
  - Unmapped or misaligned: next state RESP with cpu_err=1, cpu_rdata=0; no device is selected.
- ACCESS:
  - dev_sel, dev_we, dev_addr and dev_wdata are held stable.
  - Counter increments each cycle.
  - If dev_ack[idx]=1, capture dev_rdata slice idx into cpu_rdata (stores capture 0), set cpu_err=0, next state RESP.
  - Acks on non-selected bits are ignored.
  - If the counter reaches TIMEOUT-1 with no ack, next state RESP with cpu_err=1, cpu_rdata=0.
  - If ack and timeout fall in the same cycle, ack wins (err=0).
- RESP:
  - dev_sel=0, dev_we=0; cpu_ready=1 for exactly this cycle.
  - Next state IDLE; cpu_err and cpu_rdata are cleared on IDLE entry.
- Any cpu_req asserted in ACCESS or RESP is ignored. The CPU must hold its stall until cpu_ready and re-present the request no earlier than the cycle after RESP.
- Latency, measured from a request sampled in cycle T:
  - Mapped access with immediate ack: ACCESS at T+1, cpu_ready at T+2.
  - Ack after k ACCESS cycles: cpu_ready at T+1+k.
  - Unmapped access: cpu_ready at T+1.
  - Timeout: cpu_ready at T+1+TIMEOUT.
- Back-to-back transactions: minimum 3 cycles per mapped access (IDLE, ACCESS, RESP).

Test Plan:
- Reset: drive rst_n=0 mid-ACCESS (dev_sel=4'b0100) -> all outputs 0 asynchronously; after release, state IDLE, cpu_ready never pulses.
- Store to 0x7F14 with data 0xDEADBEEF, dev_ack[1]=1 in first ACCESS cycle -> dev_sel=4'b0010, dev_we=1, dev_addr=4'h4, dev_wdata=0xDEADBEEF in T+1; cpu_ready=1, cpu_err=0 in T+2.
- Load from 0x7F38, dev_rdata slice 3 = 0x12345678, ack after 3 ACCESS cycles -> cpu_ready at T+4 with cpu_rdata=0x12345678, cpu_err=0.
- Load from 0x7F40 (unmapped) and from 0x7F02 (misaligned) -> dev_sel stays 0; cpu_ready at T+1 with cpu_err=1, cpu_rdata=0.
- Load from 0x7F20 with no ack and dev_ack[0] toggling (wrong device) -> cpu_ready at T+17, cpu_err=1, cpu_rdata=0.
- Ack on the final timeout cycle, plus cpu_req held high during ACCESS/RESP -> cpu_err=0 with data returned; exactly one cpu_ready pulse per accepted request.

Source files
------------

// File: rtl/mmio_bridge_demux.sv
// CPU load/store port demultiplexed onto four memory-mapped devices at 0x7F00-0x7F3F.
// Each device has its own ack/data port. A timeout covers devices that never acknowledge.

module mmio_dev_port #(
  parameter int DATA_W = 32
) (
  input  logic              sel_i,
  input  logic              ack_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] rdata_o
);
  // Only the selected device's ack and data reach the shared response path.
  assign hit_o   = sel_i & ack_i;
  assign rdata_o = sel_i ? rdata_i : '0;
endmodule

module mmio_bridge_demux #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [31:0]           cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic                  cpu_ready,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_err,
  output logic [3:0]            dev_sel,
  output logic                  dev_we,
  output logic [3:0]            dev_addr,
  output logic [DATA_W-1:0]     dev_wdata,
  input  logic [3:0]            dev_ack,
  input  logic [4*DATA_W-1:0]   dev_rdata
);
  localparam int NUM_DEV = 4;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [3:0]          sel_q, sel_d;
  logic                we_q, we_d;
  logic [3:0]          addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [NUM_DEV-1:0]             ack_hit;
  logic [NUM_DEV-1:0][DATA_W-1:0] rdata_m;
  logic [DATA_W-1:0]              sel_rdata;
  logic                           ack_any;
  logic                           mapped;

  for (genvar g = 0; g < NUM_DEV; g++) begin : g_dev
    mmio_dev_port #(.DATA_W(DATA_W)) u_port (
      .sel_i   (sel_q[g]),
      .ack_i   (dev_ack[g]),
      .rdata_i (dev_rdata[g*DATA_W +: DATA_W]),
      .hit_o   (ack_hit[g]),
      .rdata_o (rdata_m[g])
    );
  end

  // sel_q is one-hot in ACCESS, so OR-merging the gated slices picks the selected device.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_DEV; i++) sel_rdata |= rdata_m[i];
    ack_any = |ack_hit;
  end

  assign mapped = (cpu_addr[31:16] == 16'h0000) &&
                  (cpu_addr[15:6]  == 10'h1FC)  &&
                  (cpu_addr[1:0]   == 2'b00);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ready_d = 1'b0;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        err_d   = 1'b0;
        rdata_d = '0;
        if (cpu_req) begin
          if (mapped) begin
            state_d = ACCESS;
            cnt_d   = '0;
            sel_d   = 4'b0001 << cpu_addr[5:4];
            we_d    = cpu_we;
            addr_d  = {cpu_addr[3:2], 2'b00};
            wdata_d = cpu_wdata;
          end else begin
            state_d = RESP;
            ready_d = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 8'd1;
        // An ack arriving on the final timeout cycle still completes cleanly.
        if (ack_any) begin
          state_d = RESP;
          ready_d = 1'b1;
          err_d   = 1'b0;
          rdata_d = we_q ? '0 : sel_rdata;
          sel_d   = '0;
          we_d    = 1'b0;
        end else if (cnt_q == TO_LAST) begin
          state_d = RESP;
          ready_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
          sel_d   = '0;
          we_d    = 1'b0;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
        err_d   = 1'b0;
        rdata_d = '0;
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign cpu_ready = ready_q;
  assign cpu_err   = err_q;
  assign cpu_rdata = rdata_q;
  assign dev_sel   = sel_q;
  assign dev_we    = we_q;
  assign dev_addr  = addr_q;
  assign dev_wdata = wdata_q;

endmodule

// File: tb/tb_mmio_bridge_demux.sv
// Directed bench for mmio_bridge_demux: expected responses are queued at issue time and
// matched by a negedge monitor against cpu_ready pulses, including the completion cycle.

module tb_mmio_bridge_demux;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cpu_req, cpu_we;
  logic [31:0]       cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready, cpu_err;
  logic [DATA_W-1:0] cpu_rdata;
  logic [3:0]        dev_sel;
  logic              dev_we;
  logic [3:0]        dev_addr;
  logic [DATA_W-1:0] dev_wdata;
  logic [3:0]        dev_ack;
  logic [4*DATA_W-1:0] dev_rdata;

  mmio_bridge_demux #(.DATA_W(DATA_W), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dev_sel(dev_sel), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_ack(dev_ack), .dev_rdata(dev_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && cpu_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_ready: cpu_ready=1 at cycle %0d with nothing outstanding", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ready_cycle", 64'(cyc), 64'(e.cyc));
        chk("cpu_err", {63'd0, cpu_err}, {63'd0, e.err});
        chk("cpu_rdata", 64'(cpu_rdata), 64'(e.rdata));
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       output int t);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    t = cyc;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_sel"},   64'(dev_sel), 64'd0);
    chk({tag, "_we"},    64'(dev_we), 64'd0);
    chk({tag, "_addr"},  64'(dev_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(dev_wdata), 64'd0);
    chk({tag, "_ready"}, 64'(cpu_ready), 64'd0);
    chk({tag, "_err"},   64'(cpu_err), 64'd0);
    chk({tag, "_rdata"}, 64'(cpu_rdata), 64'd0);
  endtask

  initial begin
    int t;
    logic [31:0] bad_addr [3];
    bad_addr[0] = 32'h0000_7F40;
    bad_addr[1] = 32'h0000_7F02;
    bad_addr[2] = 32'h1000_7F00;

    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dev_ack = '0;
    dev_rdata = {32'h1234_5678, 32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0};
    #3;
    chk_idle_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // store 0x7F14, ack in first ACCESS cycle
    issue(1'b1, 32'h0000_7F14, 32'hDEAD_BEEF, t);
    exp_q.push_back('{t + 2, 1'b0, 32'h0});
    step(); cpu_req = 1'b0;
    chk("st_sel",   64'(dev_sel), 64'h2);
    chk("st_we",    64'(dev_we), 64'h1);
    chk("st_addr",  64'(dev_addr), 64'h4);
    chk("st_wdata", 64'(dev_wdata), 64'hDEAD_BEEF);
    dev_ack = 4'b0010;
    step(); dev_ack = '0;
    chk("st_resp_sel", 64'(dev_sel), 64'h0);
    chk("st_resp_we",  64'(dev_we), 64'h0);
    step();

    // back-to-back load from device 1, immediate ack
    issue(1'b0, 32'h0000_7F10, 32'h0, t);
    exp_q.push_back('{t + 2, 1'b0, 32'hB1B1_B1B1});
    step(); cpu_req = 1'b0; dev_ack = 4'b0010;
    step(); dev_ack = '0;
    step();

    // store to device 3 returns zero data even though slice 3 is non-zero
    issue(1'b1, 32'h0000_7F3C, 32'h0BAD_F00D, t);
    exp_q.push_back('{t + 2, 1'b0, 32'h0});
    step(); cpu_req = 1'b0; dev_ack = 4'b1000;
    chk("st3_addr", 64'(dev_addr), 64'hC);
    step(); dev_ack = '0;
    step();

    // load 0x7F38, ack in third ACCESS cycle
    issue(1'b0, 32'h0000_7F38, 32'h0, t);
    exp_q.push_back('{t + 4, 1'b0, 32'h1234_5678});
    step(); cpu_req = 1'b0;
    chk("ld3_sel", 64'(dev_sel), 64'h8);
    chk("ld3_we",  64'(dev_we), 64'h0);
    step();
    step(); dev_ack = 4'b1000;
    step(); dev_ack = '0;
    step();

    // unmapped, misaligned and high-address loads: error after one cycle
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, bad_addr[i], 32'h0, t);
      exp_q.push_back('{t + 1, 1'b1, 32'h0});
      step(); cpu_req = 1'b0;
      chk($sformatf("bad%0d_sel", i), 64'(dev_sel), 64'h0);
      step();
    end

    // timeout on device 2 while other devices' ack bits toggle
    issue(1'b0, 32'h0000_7F20, 32'h0, t);
    exp_q.push_back('{t + 17, 1'b1, 32'h0});
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 1) begin
        cpu_req = 1'b0;
        chk("to_sel", 64'(dev_sel), 64'h4);
      end
      dev_ack = k[0] ? 4'b1011 : 4'b0001;
    end
    step(); dev_ack = '0;
    step();

    // ack on the last timeout cycle, cpu_req held through ACCESS and RESP
    issue(1'b0, 32'h0000_7F30, 32'h0, t);
    exp_q.push_back('{t + 17, 1'b0, 32'h1234_5678});
    for (int k = 1; k <= 16; k++) begin
      step();
      dev_ack = (k == 16) ? 4'b1000 : 4'b0000;
    end
    step(); dev_ack = '0;
    step(); cpu_req = 1'b0;
    repeat (3) step();

    // reset in the middle of an ACCESS to device 2
    issue(1'b0, 32'h0000_7F20, 32'h0, t);
    step(); cpu_req = 1'b0;
    chk("mid_sel", 64'(dev_sel), 64'h4);
    #2 rst_n = 1'b0;
    #1 chk_idle_outputs("async_rst");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (20) step();

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
